// File: rtl/pipeline_fetch.sv
// pipeline_fetch: IF-stage controller that owns the PC, resolves ID redirects and drains the pipe on HALT.
// Ports:
//   clk            system clock, rising-edge state updates
//   reset          asynchronous active-low reset
//   stall          load-use stall, holds PC and IF/ID
//   branchTaken    conditional branch in ID resolved taken
//   jumpImm        J/JAL in ID
//   jumpReg        JR/JALR in ID
//   pcPlus4Id      pcPlus4 of the ID instruction
//   extendedImm    sign-extended immediate of the ID instruction
//   registerS1     forwarded rS1 (JR target)
//   instructionId  ID instruction (J target field [25:0])
//   imemData       instruction word at instrAddr
//   instrAddr      PC to instruction memory
//   pcPlus4        instrAddr + 4
//   preInstruction instruction word handed to the datapath
//   branch         squash of the IF instruction this cycle
//   ifIdWrIn       IF/ID write enable
//   endProgram     sticky program-finished flag
//   fetchCount     instructions issued (0 unless FETCH_COUNT_EN)
//   cycleCount     cycles since reset (0 unless FETCH_COUNT_EN)
// Optional feature macro: FETCH_COUNT_EN enables the fetchCount/cycleCount counters.
module pipeline_fetch #(
   parameter logic [31:0] RESET_PC     = 32'h00000000,
   parameter logic [31:0] HALT_WORD    = 32'hFFFFFFFF,
   parameter int          DRAIN_CYCLES = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        stall,
   input  logic        branchTaken,
   input  logic        jumpImm,
   input  logic        jumpReg,
   input  logic [31:0] pcPlus4Id,
   input  logic [31:0] extendedImm,
   input  logic [31:0] registerS1,
   input  logic [31:0] instructionId,
   input  logic [31:0] imemData,
   output logic [31:0] instrAddr,
   output logic [31:0] pcPlus4,
   output logic [31:0] preInstruction,
   output logic        branch,
   output logic        ifIdWrIn,
   output logic        endProgram,
   output logic [31:0] fetchCount,
   output logic [31:0] cycleCount
);
   typedef enum logic [1:0] {RUN, DRAIN, DONE} state_t;
   state_t      state;
   logic [31:0] pc;
   logic [3:0]  drainCnt;
   logic        redirect;
   logic        haltDetect;
   logic [31:0] target;
   logic        unusedBits;
   assign unusedBits = ^instructionId[31:26];
   // Reset is folded into the combinational outputs so they show the
   // documented reset values even while the async reset is held.
   always_comb begin
      redirect       = reset && state == RUN && !stall && (jumpReg || jumpImm || branchTaken);
      target         = jumpReg ? registerS1
                     : jumpImm ? {pcPlus4Id[31:28], instructionId[25:0], 2'b00}
                     : pcPlus4Id + (extendedImm << 2);
      haltDetect     = reset && state == RUN && !stall && !redirect && imemData == HALT_WORD;
      instrAddr      = pc;
      pcPlus4        = pc + 32'd4;
      branch         = redirect;
      ifIdWrIn       = !reset || state == DONE || !stall;
      preInstruction = (state == RUN && !haltDetect) ? imemData : 32'h0;
   end
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state      <= RUN;
         pc         <= RESET_PC;
         drainCnt   <= 4'd0;
         endProgram <= 1'b0;
      end else begin
         case (state)
            RUN: begin
               if (!stall) begin
                  if (redirect)
                     pc <= target;
                  else if (haltDetect) begin
                     state    <= DRAIN;
                     drainCnt <= 4'(DRAIN_CYCLES - 1);
                  end else
                     pc <= pc + 32'd4;
               end
            end
            DRAIN: begin
               if (!stall) begin
                  if (drainCnt == 4'd0) begin
                     state      <= DONE;
                     endProgram <= 1'b1;
                  end else
                     drainCnt <= drainCnt - 4'd1;
               end
            end
            default: state <= DONE;
         endcase
      end
   end
`ifdef FETCH_COUNT_EN
   logic fetchOk;
   assign fetchOk = state == RUN && !stall && !redirect && !haltDetect;
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         fetchCount <= 32'h0;
         cycleCount <= 32'h0;
      end else begin
         if (fetchOk)
            fetchCount <= fetchCount + 32'd1;
         if (!endProgram)
            cycleCount <= cycleCount + 32'd1;
      end
   end
`else
   assign fetchCount = 32'h0;
   assign cycleCount = 32'h0;
`endif
endmodule

// File: tb/tb_pipeline_fetch.sv
// tb_pipeline_fetch: scoreboard bench for pipeline_fetch redirects, stalls, HALT drain and counters.
module tb_pipeline_fetch;
   localparam logic [31:0] HALT = 32'hFFFFFFFF;
   localparam int DC = 4;
   logic clk = 0, reset = 0, stall = 0, branchTaken = 0, jumpImm = 0, jumpReg = 0;
   logic [31:0] pcPlus4Id = 0, extendedImm = 0, registerS1 = 0, instructionId = 0, imemData = 0;
   logic [31:0] instrAddr, pcPlus4, preInstruction, fetchCount, cycleCount;
   logic branch, ifIdWrIn, endProgram;
   pipeline_fetch dut (
      .clk(clk), .reset(reset), .stall(stall), .branchTaken(branchTaken), .jumpImm(jumpImm),
      .jumpReg(jumpReg), .pcPlus4Id(pcPlus4Id), .extendedImm(extendedImm), .registerS1(registerS1),
      .instructionId(instructionId), .imemData(imemData), .instrAddr(instrAddr), .pcPlus4(pcPlus4),
      .preInstruction(preInstruction), .branch(branch), .ifIdWrIn(ifIdWrIn), .endProgram(endProgram),
      .fetchCount(fetchCount), .cycleCount(cycleCount)
   );
   always #5 clk = ~clk;
   typedef struct {
      logic [31:0] pc;
      logic        endp;
      logic [31:0] fc;
      logic [31:0] cc;
   } exp_t;
   exp_t sb[$];
   int total = 0, bad = 0;
   logic [31:0] mPc, mFc, mCc, haltAt, ccSave;
   int mState, mCnt;
   logic mEnd;
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask
   task automatic checkCounters(input logic [31:0] fc, input logic [31:0] cc);
`ifdef FETCH_COUNT_EN
      check("fetchCount", fetchCount, fc);
      check("cycleCount", cycleCount, cc);
`else
      check("fetchCount", fetchCount, 32'h0);
      check("cycleCount", cycleCount, 32'h0);
`endif
   endtask
   task automatic doRst();
      reset = 0; stall = 1; branchTaken = 1; jumpReg = 0; jumpImm = 0; imemData = HALT;
      #1;
      check("rstAddr", instrAddr, 32'h0);
      check("rstPc4", pcPlus4, 32'h4);
      check("rstBranch", branch, 0);
      check("rstWr", ifIdWrIn, 1);
      check("rstPre", preInstruction, HALT);
      check("rstEnd", endProgram, 0);
      checkCounters(0, 0);
      mPc = 0; mState = 0; mCnt = 0; mEnd = 0; mFc = 0; mCc = 0;
      @(posedge clk); #1;
      stall = 0; branchTaken = 0; reset = 1;
   endtask
   task automatic step(input logic st, input logic bt, input logic ji, input logic jr,
                       input logic [31:0] p4, input logic [31:0] imm, input logic [31:0] rs1, input logic [31:0] iid);
      logic red, halt;
      logic [31:0] tgt, im;
      exp_t e;
      im = (mPc == haltAt) ? HALT : 32'h20;
      stall = st; branchTaken = bt; jumpImm = ji; jumpReg = jr;
      pcPlus4Id = p4; extendedImm = imm; registerS1 = rs1; instructionId = iid; imemData = im;
      red  = mState == 0 && !st && (jr || ji || bt);
      tgt  = jr ? rs1 : ji ? {p4[31:28], iid[25:0], 2'b00} : p4 + (imm << 2);
      halt = mState == 0 && !st && !red && im == HALT;
      @(negedge clk);
      check("branch", branch, red);
      check("ifIdWr", ifIdWrIn, (mState == 2) ? 1'b1 : !st);
      check("preInstr", preInstruction, (mState == 0 && !halt) ? im : 32'h0);
      check("pcPlus4", pcPlus4, mPc + 32'd4);
      if (!mEnd) mCc++;
      if (mState == 0) begin
         if (!st) begin
            if (red) mPc = tgt;
            else if (halt) begin mState = 1; mCnt = DC - 1; end
            else begin mPc += 4; mFc++; end
         end
      end else if (mState == 1 && !st) begin
         if (mCnt == 0) begin mState = 2; mEnd = 1; end
         else mCnt--;
      end
      e = '{mPc, mEnd, mFc, mCc};
      sb.push_back(e);
      @(posedge clk); #1;
      if (sb.size() == 0) check("sbEmpty", 1, 0);
      else begin
         e = sb.pop_front();
         check("instrAddr", instrAddr, e.pc);
         check("endProgram", endProgram, e.endp);
         checkCounters(e.fc, e.cc);
      end
   endtask
   task automatic nop();
      step(0, 0, 0, 0, 0, 0, 0, 0);
   endtask
   initial begin
      haltAt = 32'hFFFF0000;
      doRst();
      nop(); check("seq4", instrAddr, 32'h4);
      nop(); check("seq8", instrAddr, 32'h8);
      step(1, 1, 0, 0, 32'h100, 32'h4, 0, 0);
      step(1, 1, 0, 0, 32'h100, 32'h4, 0, 0);
      check("stallHold", instrAddr, 32'h8);
      nop(); check("afterStall", instrAddr, 32'hC);
      step(0, 1, 0, 0, 32'h100, 32'hFFFFFFFE, 0, 0); check("brTarget", instrAddr, 32'hF8);
      step(0, 0, 1, 1, 32'h0, 0, 32'h400, 32'h0); check("jrPrio", instrAddr, 32'h400);
      step(0, 1, 1, 0, 32'h30000000, 32'h8, 32'h999, 32'hFC000010); check("jImm", instrAddr, 32'h30000040);
      step(0, 0, 0, 1, 0, 0, 32'hFFFFFFFC, 0); check("wrapPc4", pcPlus4, 32'h0);
      nop(); check("wrapPc", instrAddr, 32'h0);
      haltAt = 32'h10;
      step(0, 0, 0, 1, 0, 0, 32'h10, 0);
      step(1, 0, 0, 0, 0, 0, 0, 0);
      step(0, 0, 0, 1, 0, 0, 32'h10, 0);
      nop(); check("detectEnd", endProgram, 0);
      step(0, 1, 1, 1, 32'h100, 32'h4, 32'h40, 32'h5);
      step(1, 0, 0, 0, 0, 0, 0, 0);
      nop();
      nop(); check("drainEnd", endProgram, 0);
      nop(); check("doneEnd", endProgram, 1);
      check("donePc", instrAddr, 32'h10);
      ccSave = cycleCount;
      step(1, 1, 1, 1, 32'h100, 32'h4, 32'h40, 32'h5);
      nop();
      check("ccFrozen", cycleCount, ccSave);
      check("sticky", endProgram, 1);
      doRst();
      haltAt = 32'h14;
      for (int i = 0; i < 6; i++) nop();
`ifdef FETCH_COUNT_EN
      check("fetch5", fetchCount, 32'd5);
`endif
      check("haltHold", instrAddr, 32'h14);
      nop();
      doRst();
      nop(); check("postRst", instrAddr, 32'h4);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
